// File: rtl/iob_cache_be_scheduler.sv
// Back-end scheduler: serialises write-through drains and line
// replacements so only one back-end transaction is outstanding.
module iob_cache_be_scheduler #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int WORD_OFFSET_W = 3,
  parameter int STARVE_MAX    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_write_valid,
  input  logic [ADDR_W-$clog2(DATA_W/8)-1:0] req_write_addr,
  input  logic [DATA_W-1:0] req_write_wdata,
  input  logic [DATA_W/8-1:0] req_write_wstrb,
  output logic req_write_ready,
  input  logic req_replace_valid,
  input  logic [ADDR_W-$clog2(DATA_W/8)-WORD_OFFSET_W-1:0] req_replace_addr,
  output logic req_replace,
  output logic be_write_valid,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0] be_write_addr,
  output logic [DATA_W-1:0] be_write_wdata,
  output logic [DATA_W/8-1:0] be_write_wstrb,
  input  logic be_write_ready,
  output logic be_replace_valid,
  output logic [ADDR_W-$clog2(DATA_W/8)-WORD_OFFSET_W-1:0] be_replace_addr,
  input  logic be_replace
);

  localparam int NBYTES   = DATA_W / 8;
  localparam int NBYTES_W = $clog2(NBYTES);
  localparam int WA_W     = ADDR_W - NBYTES_W;
  localparam int LA_W     = WA_W - WORD_OFFSET_W;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    REPL_START,
    REPL_BUSY,
    REPL_DONE
  } state_t;

  state_t state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic [WA_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NBYTES-1:0] wstrb_q, wstrb_d;
  logic [LA_W-1:0] raddr_q, raddr_d;

  logic [LA_W-1:0] wline;
  logic hazard;
  logic grant_w;

  assign wline = req_write_addr[WA_W-1:WORD_OFFSET_W];
  assign hazard = req_write_valid & req_replace_valid
                & (wline == req_replace_addr);

  // A waiting write wins on a same-line hazard or once starved out
  assign grant_w = req_write_valid
                 & (~req_replace_valid | hazard
                    | (starve_cnt_q == SMAX));

  always_comb begin
    state_d          = state_q;
    starve_cnt_d     = starve_cnt_q;
    waddr_d          = waddr_q;
    wdata_d          = wdata_q;
    wstrb_d          = wstrb_q;
    raddr_d          = raddr_q;
    req_write_ready  = 1'b0;
    req_replace      = 1'b0;
    be_write_valid   = 1'b0;
    be_replace_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_w) begin
          state_d      = WRITE;
          starve_cnt_d = '0;
          waddr_d      = req_write_addr;
          wdata_d      = req_write_wdata;
          wstrb_d      = req_write_wstrb;
        end else if (req_replace_valid) begin
          state_d = REPL_START;
          raddr_d = req_replace_addr;
          if (req_write_valid && starve_cnt_q != SMAX)
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
      end
      WRITE: begin
        be_write_valid  = 1'b1;
        req_write_ready = be_write_ready;
        if (be_write_ready)
          state_d = IDLE;
      end
      REPL_START: begin
        be_replace_valid = 1'b1;
        req_replace      = 1'b1;
        if (be_replace)
          state_d = REPL_BUSY;
      end
      REPL_BUSY: begin
        req_replace = 1'b1;
        if (!be_replace)
          state_d = REPL_DONE;
      end
      // One dead cycle so the stale request of the filled line is dropped
      REPL_DONE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      raddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      raddr_q      <= raddr_d;
    end
  end

  assign be_write_addr   = waddr_q;
  assign be_write_wdata  = wdata_q;
  assign be_write_wstrb  = wstrb_q;
  assign be_replace_addr = raddr_q;

endmodule

// File: doc/iob_cache_be_scheduler.md
Name: iob_cache_be_scheduler

Overview:
Sits between the cache control logic and the AXI back-end. It serialises the two back-end requesters, the write-through buffer drain and cache-line replacement, onto the back-end so that at most one back-end transaction is outstanding. It enforces same-line write-before-read ordering and bounds write starvation behind back-to-back replacements. Write-through policy only: one word per write.

Parameters:
ADDR_W, 32, byte address width.
DATA_W, 32, front-end word width; NBYTES = DATA_W/8, NBYTES_W = log2(NBYTES).
WORD_OFFSET_W, 3, log2(words per cache line).
STARVE_MAX, 4, max consecutive replacements granted while a write waits (1..15).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_write_valid  in  1  write-buffer request
req_write_addr  in  ADDR_W-NBYTES_W  word address
req_write_wdata  in  DATA_W  write data
req_write_wstrb  in  NBYTES  byte strobes
req_write_ready  out  1  one-cycle completion pulse to write buffer
req_replace_valid  in  1  line-replacement request (level)
req_replace_addr  in  ADDR_W-NBYTES_W-WORD_OFFSET_W  line address
req_replace  out  1  replacement in progress
be_write_valid  out  1  to back-end write channel
be_write_addr  out  ADDR_W-NBYTES_W  registered copy
be_write_wdata  out  DATA_W  registered copy
be_write_wstrb  out  NBYTES  registered copy
be_write_ready  in  1  back-end write done
be_replace_valid  out  1  to back-end read channel
be_replace_addr  out  ADDR_W-NBYTES_W-WORD_OFFSET_W  registered copy
be_replace  in  1  back-end replacement busy

Behaviour:
- States: IDLE, WRITE, REPL_START, REPL_BUSY, REPL_DONE. Reset: IDLE, all outputs 0, capture registers 0, starve_cnt 0. Reset mid-transaction aborts to IDLE the next edge; the back-end is reset alongside.
- wline = req_write_addr[ADDR_W-NBYTES_W-1:WORD_OFFSET_W]; hazard = req_write_valid & req_replace_valid & (wline == req_replace_addr).
- IDLE arbitration, decided in one cycle and registered at the edge:
  - write only -> WRITE.
  - replace only -> REPL_START.
  - both with hazard -> WRITE.
  - both, no hazard, starve_cnt == STARVE_MAX -> WRITE.
  - both otherwise -> REPL_START.
  - none -> stay.
- On a grant, capture the address, data and strobe of the granted request into the be_* registers.
- starve_cnt: cleared on a write grant. Incremented, saturating at STARVE_MAX, on a replacement grant while req_write_valid=1. Unchanged otherwise.
- WRITE:
  - be_write_valid=1.
  - When be_write_ready=1: req_write_ready=1 in that same cycle (combinational from be_write_ready & WRITE), then -> IDLE. be_write_valid is low the following cycle.
  - The upstream drops or advances req_write_* in the cycle after req_write_ready.
- REPL_START: be_replace_valid=1 and req_replace=1. When be_replace=1 -> REPL_BUSY. No timeout.
- REPL_BUSY: req_replace=1, be_replace_valid=0. When be_replace=0 -> REPL_DONE.
- REPL_DONE: req_replace=0. No grant for one cycle, so the stale req_replace_valid of the just-filled line is ignored. Then -> IDLE.
- Latency:
  - Write request in IDLE to be_write_valid: 1 cycle.
  - Replace request to be_replace_valid: 1 cycle.
  - Minimum write turnaround: 2 cycles.
- Requests that arrive while not in IDLE are held by the requester and arbitrated on return to IDLE.
- be_* payload registers are stable while the matching valid or busy is high.

Test Plan:
1. Write only: write addr 0x0000_0010, wdata 0xDEADBEEF, wstrb 0xF. be_write_valid rises at cycle +1 with the same payload. be_write_ready is held low 3 cycles, then high 1. req_write_ready pulses in that cycle; state returns to IDLE.
2. Replace only: line addr 0x12. be_replace_valid rises at +1. be_replace goes high after 2 cycles and stays high 8 cycles. req_replace stays high throughout; req_replace_valid is still high in REPL_DONE and is not re-granted.
3. Hazard: write addr 0x0000_0098 (line 0x13) and replace line 0x13 both valid in IDLE. WRITE is granted first and the replacement starts only after req_write_ready.
4. Starvation with STARVE_MAX=4: write (line 0x1) held valid while distinct-line replacements (0x20, 0x21, ...) stay pending. Exactly 4 replacements are granted, then the write; starve_cnt reads 0 after the write grant.
5. Reset in REPL_BUSY: assert rst for 1 cycle. Next cycle state is IDLE, all outputs are 0 and starve_cnt is 0.
6. Back-to-back writes: three write requests, each acknowledged immediately. be_write_valid shows a 1-cycle gap between requests and the payloads appear in order.
